aes_inv_cipher_iter: RTL and testbench

//  Iterative AES inverse cipher: one inverse round per clock, decrypting a 128-bit block with externally supplied round keys.

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_inv_cipher_iter_if.sv | 21 ++
 rtl/aes_inv_sbox.sv | 28 ++
 rtl/aes_inv_cipher_iter.sv | 92 +++++++++
 tb/tb_aes_inv_cipher_iter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse cipher.
// Byte i of a state sits at bits [8*i +: 8], with row = i%4 and column = i/4.
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } aes_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Row r rotates right by r: out[r+4c] = in[r+4*((c-r) mod 4)].
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+4-r)%4)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[8*(4*c+0) +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c+0) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[8*(4*c+1) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[8*(4*c+2) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[8*(4*c+3) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext-in / plaintext-out handshakes plus the round-key lookup port.
interface aes_inv_cipher_iter_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] data_i;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] data_o;

  modport master (
    output in_valid_i, data_i, rk_i, out_ready_i,
    input  in_ready_o, rk_idx_o, out_valid_o, data_o
  );

  modport slave (
    input  in_valid_i, data_i, rk_i, out_ready_i,
    output in_ready_o, rk_idx_o, out_valid_o, data_o
  );
endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine transform, then GF(2^8) inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_aff;
  logic [7:0] w_sq;
  logic [7:0] w_acc;

  assign w_aff = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]}
               ^ {i_byte[1:0], i_byte[7:2]} ^ 8'h05;

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as required.
  always_comb begin
    w_sq  = gmul(w_aff, w_aff);
    w_acc = w_sq;
    for (int unsigned k = 1; k < 7; k++) begin
      w_sq  = gmul(w_sq, w_sq);
      w_acc = gmul(w_acc, w_sq);
    end
  end

  assign o_byte = w_acc;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one inverse round per clock, round keys fetched by index.
// Build option AES_INV_ZEROIZE_EN: clear the state on output handshake, data_o reads 0 unless valid.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_AES128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_inv_cipher_iter_if.slave  bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  aes_fsm_e   r_fsm;
  aes_fsm_e   w_fsm_nxt;
  aes_state_t r_state;
  aes_state_t w_state_nxt;
  logic [3:0] r_rnd;
  logic [3:0] w_rnd_nxt;

  aes_state_t w_shifted;
  aes_state_t w_sub;

  assign w_shifted = inv_shift_rows(r_state);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .i_byte (w_shifted[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_rnd   <= '0;
      r_state <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_rnd   <= w_rnd_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_rnd_nxt       = r_rnd;
    w_state_nxt     = r_state;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.rk_idx_o    = NR_IDX;
    case (r_fsm)
      ST_IDLE: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_valid_i) begin
          w_state_nxt = bus.data_i ^ bus.rk_i;
          w_rnd_nxt   = NR_IDX - 4'd1;
          w_fsm_nxt   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        bus.rk_idx_o = r_rnd;
        w_state_nxt  = inv_mix_columns(w_sub ^ bus.rk_i);
        if (r_rnd == 4'd1) w_fsm_nxt = ST_FINAL;
        else               w_rnd_nxt = r_rnd - 4'd1;
      end
      ST_FINAL: begin
        bus.rk_idx_o = '0;
        w_state_nxt  = w_sub ^ bus.rk_i;
        w_fsm_nxt    = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) begin
          w_fsm_nxt = ST_IDLE;
`ifdef AES_INV_ZEROIZE_EN
          w_state_nxt = '0;
`endif
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

`ifdef AES_INV_ZEROIZE_EN
  assign bus.data_o = (r_fsm == ST_DONE) ? r_state : '0;
`else
  assign bus.data_o = r_state;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: forward-AES golden model, key-store model, output scoreboard.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  aes_inv_cipher_iter_if bus();

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t         vec[5];
  logic [7:0]   sb[256];
  logic [127:0] rk_mem[11];
  logic [31:0]  w[44];
  logic [127:0] exp_q[$];
  int unsigned  acc_q[$];
  int unsigned  acc_log[$];
  int unsigned  cyc = 0;
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  int unsigned  last_hs = 0;
  int unsigned  last_acc = 0;
  int unsigned  mon_a;
  int unsigned  t5_base;
  logic [127:0] cur_exp = '0;
  logic [127:0] mon_e;
  logic         prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb bus.rk_i = (bus.rk_idx_o <= 4'd10) ? rk_mem[bus.rk_idx_o] : '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event did not occur (cycle %0d)", nm, cyc);
  endtask

  // ---------------- golden model: forward AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] to_state(input logic [127:0] be);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = be[8*(15-i) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ rk_mem[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = sb[s[8*i +: 8]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++)
          t[8*(rr+4*c) +: 8] = s[8*(rr+4*((c+rr)%4)) +: 8];
      s = t;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
          t[32*c    +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[32*c+8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        s = t;
      end
      s ^= rk_mem[r];
    end
    return s;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid_i && bus.in_ready_o) begin
        exp_q.push_back(cur_exp);
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
        last_acc = cyc + 1;
      end
      if (bus.out_valid_o && !prev_ov) begin
        if (acc_q.size() == 0) miss("SPURIOUS_VALID_ACCEPT");
        else begin
          mon_a = acc_q.pop_front();
          chk("LATENCY", cyc, mon_a + 10);
        end
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) miss("SPURIOUS_OUTPUT");
        else begin
          mon_e = exp_q.pop_front();
          chk("PLAINTEXT", bus.data_o, mon_e);
        end
        last_hs = cyc + 1;
      end
    end
    prev_ov = bus.out_valid_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    int n = 0;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.data_i     = ct;
    cur_exp        = pt;
    @(negedge clk);
    while (!bus.in_ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready_o) miss("ACCEPT_TIMEOUT");
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) miss("DRAIN_TIMEOUT");
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid_o) miss("VALID_TIMEOUT");
  endtask

  initial begin
    #400000;
    $display("FAIL WATCHDOG: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] key_be, p;
    logic [31:0]  t;
    logic [7:0]   inv, rc;
    int           n;

    // S-box by brute-force GF inverse plus affine map
    for (int b = 0; b < 256; b++) begin
      inv = '0;
      for (int x = 1; x < 256; x++) if (gm(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    key_be = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = key_be[32*(3-i) +: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_mem[r] = to_state({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});

    vec[0] = '{ct: to_state(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
               pt: to_state(128'h00112233445566778899aabbccddeeff)};
    for (int i = 1; i < 5; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      vec[i] = '{ct: encrypt(p), pt: p};
    end

    bus.in_valid_i  = 1'b0;
    bus.data_i      = '0;
    bus.out_ready_i = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("RST_IN_READY", bus.in_ready_o, 1);
    chk("RST_OUT_VALID", bus.out_valid_o, 0);
    chk("RST_DATA_O", bus.data_o, 0);
    chk("RST_RK_IDX", bus.rk_idx_o, 10);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // FIPS-197 C.1 block with full round-key index trace
    @(negedge clk);
    chk("RK_IDLE", bus.rk_idx_o, 10);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.data_i     = vec[0].ct;
    cur_exp        = vec[0].pt;
    @(negedge clk);
    chk("IN_READY_ACCEPT", bus.in_ready_o, 1);
    chk("RK_ACCEPT", bus.rk_idx_o, 10);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      @(negedge clk);
      chk("RK_TRACE", bus.rk_idx_o, k);
    end
    @(negedge clk);
    chk("T1_OUT_VALID", bus.out_valid_o, 1);
    @(negedge clk);
    chk("RK_BACK_IDLE", bus.rk_idx_o, 10);
    chk("IN_READY_BACK", bus.in_ready_o, 1);
    chk("OUT_VALID_DROP", bus.out_valid_o, 0);
`ifdef AES_INV_ZEROIZE_EN
    chk("DATA_AFTER_HS", bus.data_o, 0);
`else
    chk("DATA_AFTER_HS", bus.data_o, vec[0].pt);
`endif

    // backpressure hold with an ignored second request
    bus.out_ready_i = 1'b0;
    send(vec[0].ct, vec[0].pt);
    wait_valid();
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.data_i     = vec[1].ct;
    cur_exp        = vec[1].pt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("HOLD_DATA", bus.data_o, vec[0].pt);
      chk("HOLD_VALID", bus.out_valid_o, 1);
      chk("HOLD_IN_READY", bus.in_ready_o, 0);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    chk("SECOND_ACCEPT_EDGE", last_acc, last_hs + 1);
    wait_drain();

    // back-to-back table of vectors
    t5_base = acc_log.size();
    for (int i = 1; i < 5; i++) send(vec[i].ct, vec[i].pt);
    wait_drain();
    if (acc_log.size() != t5_base + 4) miss("B2B_ACCEPT_COUNT");
    else
      for (int i = 0; i < 3; i++)
        chk("ISSUE_INTERVAL", acc_log[t5_base+i+1] - acc_log[t5_base+i], 12);

    // reset in the middle of a block
    send(vec[2].ct, vec[2].pt);
    n = 0;
    @(negedge clk);
    while (bus.rk_idx_o != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.rk_idx_o != 4'd5) miss("ROUND5_TIMEOUT");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("MIDRST_OUT_VALID", bus.out_valid_o, 0);
    chk("MIDRST_IN_READY", bus.in_ready_o, 1);
    chk("MIDRST_DATA_O", bus.data_o, 0);
    chk("MIDRST_RK_IDX", bus.rk_idx_o, 10);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    send(vec[0].ct, vec[0].pt);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
